counter_ctrl: RTL and testbench
===============================

# counter_ctrl

Command-driven controller that sits in front of the team's run/pause/stop up/down counter core and drives that core's control pins: `start`, `continue_1`, `load_en`, `load`, `upordown` and a dedicated core reset. It accepts one-word commands over a valid/ready handshake and sequences the core legally, including forcing a core reset when a reload is requested mid-run. It also counts rising edges of the core's `pulse` (count == max) and raises a one-cycle `irq` when a programmed wrap target is reached.

## Interface
- `BIT_WIDTH`, 32: width of `cmd_data` and `cnt_load`.
- `WRAP_WIDTH`, 16: width of the wrap counter and the wrap target.
- `clk`  in  1  clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  3  0 NOP, 1 LOAD, 2 RUN, 3 PAUSE, 4 RESUME, 5 STOP, 6 SET_DIR, 7 SET_WRAPS.
- `cmd_data`  in  BIT_WIDTH  operand: load value, direction in bit 0, or wrap target in `[WRAP_WIDTH-1:0]`.
- `cnt_reset`  out  1  core reset; equals `reset | rst_r`.
- `cnt_start`  out  1  core `start`.
- `cnt_continue`  out  1  core `continue_1`.
- `cnt_load_en`  out  1  core `load_en`; constant 1 out of reset.
- `cnt_load`  out  BIT_WIDTH  core load value, equal to `load_r`.
- `cnt_dir`  out  1  core `upordown`; 1 = up.
- `cnt_pulse`  in  1  core `pulse`; a level input.
- `state`  out  3  controller state code.
- `wrap_cnt`  out  WRAP_WIDTH  wraps counted since the last clear.
- `irq`  out  1  one-cycle pulse when the wrap target is reached.
- `cmd_err`  out  1  one-cycle pulse on an illegal command.

## Operation
- **States:** IDLE=0, RUN=1, PAUSE=2, STOP=3, FLUSH=4.
  - A command is accepted on an edge where `cmd_valid & cmd_ready`.
  - `cmd_ready` = 1 in every state except FLUSH.
- **IDLE**
  - LOAD: `load_r <= cmd_data`; stay in IDLE.
  - RUN: go to RUN; clear `wrap_cnt`.
  - PAUSE, RESUME, STOP: `cmd_err`; stay in IDLE.
- **RUN**
  - PAUSE → PAUSE.
  - STOP → STOP.
  - RUN: clear `wrap_cnt`; stay in RUN.
  - RESUME: `cmd_err`.
  - LOAD: `load_r <= cmd_data`, `rst_r <= 1`, go to FLUSH.
- **PAUSE**
  - RESUME → RUN.
  - STOP → STOP.
  - LOAD → FLUSH, same actions as in RUN.
  - RUN: clear `wrap_cnt`; go to RUN.
  - PAUSE: `cmd_err`.
- **STOP**
  - RUN → RUN; clear `wrap_cnt`.
  - LOAD → FLUSH.
  - PAUSE, RESUME: `cmd_err`.
- **FLUSH:** lasts exactly one cycle, then `rst_r <= 0` and the next state is IDLE.
- **State-independent commands**
  - NOP: no effect.
  - SET_DIR: `dir_r <= cmd_data[0]` in any state; takes effect immediately, including mid-run.
  - SET_WRAPS: `tgt_r <= cmd_data[WRAP_WIDTH-1:0]` in any state.
- **Output decode (from registered state)**
  - `cnt_start` = 1 in RUN and PAUSE; 0 otherwise.
  - `cnt_continue` = 0 only in PAUSE; 1 otherwise.
- **Wrap counting**
  - `pulse_q` registers `cnt_pulse`. A wrap is `cnt_pulse & ~pulse_q`, counted only while the state is RUN.
  - `wrap_cnt` saturates at all-ones.
- **Wrap target**
  - When a counted wrap makes `wrap_cnt == tgt_r` and `tgt_r != 0`: `irq` = 1 for the following cycle.
  - Saturation or repeated equality never re-fires `irq`; only a new increment reaching the target does.
- **Simultaneous events**
  - A command that clears `wrap_cnt` (RUN, or LOAD in any state) beats a same-cycle wrap; the result is 0 and there is no `irq`.
  - A PAUSE or STOP accepted in the same cycle as a wrap edge still counts that wrap.

## Timing
- **Reset values**
  - state = IDLE, `cmd_ready` = 1.
  - `cnt_reset` = 1 while `reset` is high.
  - `cnt_start` = 0, `cnt_continue` = 1, `cnt_load_en` = 0.
  - `cnt_load` = 0, `cnt_dir` = 1.
  - `wrap_cnt` = 0, `tgt_r` = 0, `irq` = 0, `cmd_err` = 0, `pulse_q` = 0.
- **Latency:** all outputs are registered. A command accepted at edge k is visible on the outputs after edge k; the core samples it at edge k+1.
- **LOAD from RUN, PAUSE or STOP**
  - `cnt_reset` = 1 in cycle k+1.
  - State = IDLE and `cmd_ready` = 1 in cycle k+2.
  - The core holds `cnt_load` from then on.
- **Reset mid-operation:** returns every register to its reset value at the next edge. Any in-flight FLUSH is abandoned.
- **Handshake:** the command is consumed on the accepting edge. `cmd_valid` held high issues a new command every ready cycle.

## Configuration
- `COUNTER_CTRL_AUTO_STOP_EN`
  - **Defined:** the cycle that raises `irq` also moves RUN → STOP, so `cnt_start` = 0 in that same cycle.
  - **Undefined:** `irq` only; the state is unchanged.

## Test plan
- Reset, then idle: `cnt_reset` = 1 during reset; afterwards state 0, `cnt_load_en` = 1, `cnt_start` = 0, `cmd_ready` = 1.
- LOAD 0x2A in IDLE, then RUN: `cnt_load` = 0x2A next cycle; after RUN `cnt_start` = 1, `cnt_continue` = 1, `wrap_cnt` = 0.
- RUN, then PAUSE, RESUME, STOP, RUN: `cnt_continue` goes 0 then 1; STOP gives `cnt_start` = 0; a second RUN clears `wrap_cnt`. PAUSE issued in IDLE gives `cmd_err` = 1 for one cycle.
- LOAD 0x10 while RUN: `cmd_ready` = 0 and `cnt_reset` = 1 for exactly one cycle, then IDLE with `cnt_load` = 0x10.
- SET_WRAPS 3, RUN, drive `cnt_pulse` high for 2 cycles ×3 bursts:
  - `wrap_cnt` steps 1, 2, 3; `irq` pulses once on the third.
  - With `COUNTER_CTRL_AUTO_STOP_EN` defined, state = STOP; otherwise state = RUN.
- Wrap edge in the same cycle as RUN accepted while already in RUN: `wrap_cnt` = 0, `irq` = 0.

Source files
------------

// File: rtl/counter_ctrl.sv
// Command-driven sequencer for the run/pause/stop up/down counter core, with wrap counting and irq.
// Optional: define COUNTER_CTRL_AUTO_STOP_EN to stop the core in the same cycle irq is raised.
module counter_ctrl #(
  parameter int BIT_WIDTH  = 32,
  parameter int WRAP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [BIT_WIDTH-1:0]  cmd_data,
  output logic                  cnt_reset,
  output logic                  cnt_start,
  output logic                  cnt_continue,
  output logic                  cnt_load_en,
  output logic [BIT_WIDTH-1:0]  cnt_load,
  output logic                  cnt_dir,
  input  logic                  cnt_pulse,
  output logic [2:0]            state,
  output logic [WRAP_WIDTH-1:0] wrap_cnt,
  output logic                  irq,
  output logic                  cmd_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    STOP  = 3'd3,
    FLUSH = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_LOAD      = 3'd1;
  localparam logic [2:0] OP_RUN       = 3'd2;
  localparam logic [2:0] OP_PAUSE     = 3'd3;
  localparam logic [2:0] OP_RESUME    = 3'd4;
  localparam logic [2:0] OP_STOP      = 3'd5;
  localparam logic [2:0] OP_SET_DIR   = 3'd6;
  localparam logic [2:0] OP_SET_WRAPS = 3'd7;

  localparam logic [WRAP_WIDTH-1:0] WRAP_ONE = WRAP_WIDTH'(1);

  state_t                cur_state, next_state;
  logic [BIT_WIDTH-1:0]  load_r, next_load;
  logic [WRAP_WIDTH-1:0] tgt_r, next_tgt;
  logic [WRAP_WIDTH-1:0] wrap_r, next_wrap, wrap_inc;
  logic                  dir_r, next_dir;
  logic                  rst_r, next_rst;
  logic                  irq_r, next_irq;
  logic                  err_r, next_err;
  logic                  load_en_r;
  logic                  pulse_q;
  logic                  accept, clear_wraps, wrap_edge;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= IDLE;
      load_r    <= '0;
      tgt_r     <= '0;
      wrap_r    <= '0;
      dir_r     <= 1'b1;
      rst_r     <= 1'b0;
      irq_r     <= 1'b0;
      err_r     <= 1'b0;
      load_en_r <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      cur_state <= next_state;
      load_r    <= next_load;
      tgt_r     <= next_tgt;
      wrap_r    <= next_wrap;
      dir_r     <= next_dir;
      rst_r     <= next_rst;
      irq_r     <= next_irq;
      err_r     <= next_err;
      load_en_r <= 1'b1;
      pulse_q   <= cnt_pulse;
    end
  end

  // Command decode; a reload outside IDLE must flush the core through its reset.
  always_comb begin
    accept      = cmd_valid && (cur_state != FLUSH);
    next_state  = cur_state;
    next_load   = load_r;
    next_tgt    = tgt_r;
    next_dir    = dir_r;
    next_rst    = 1'b0;
    next_err    = 1'b0;
    clear_wraps = 1'b0;
    if (cur_state == FLUSH) begin
      next_state = IDLE;
    end else if (accept) begin
      case (cmd_op)
        OP_NOP: ;
        OP_LOAD: begin
          next_load   = cmd_data;
          clear_wraps = 1'b1;
          if (cur_state != IDLE) begin
            next_state = FLUSH;
            next_rst   = 1'b1;
          end
        end
        OP_RUN: begin
          clear_wraps = 1'b1;
          next_state  = RUN;
        end
        OP_PAUSE: begin
          if (cur_state == RUN) next_state = PAUSE;
          else next_err = 1'b1;
        end
        OP_RESUME: begin
          if (cur_state == PAUSE) next_state = RUN;
          else next_err = 1'b1;
        end
        OP_STOP: begin
          if (cur_state == RUN || cur_state == PAUSE) next_state = STOP;
          else if (cur_state == IDLE) next_err = 1'b1;
        end
        OP_SET_DIR:   next_dir = cmd_data[0];
        OP_SET_WRAPS: next_tgt = cmd_data[WRAP_WIDTH-1:0];
        default: ;
      endcase
    end

    // Clearing commands win over a same-cycle wrap; saturation blocks both count and irq.
    wrap_edge = cnt_pulse && !pulse_q && (cur_state == RUN);
    wrap_inc  = wrap_r + WRAP_ONE;
    next_wrap = wrap_r;
    next_irq  = 1'b0;
    if (clear_wraps) begin
      next_wrap = '0;
    end else if (wrap_edge && !(&wrap_r)) begin
      next_wrap = wrap_inc;
      next_irq  = (wrap_inc == tgt_r) && (tgt_r != '0);
    end
`ifdef COUNTER_CTRL_AUTO_STOP_EN
    if (next_irq && cur_state == RUN) next_state = STOP;
`endif
  end

  assign cmd_ready    = (cur_state != FLUSH);
  assign cnt_reset    = reset | rst_r;
  assign cnt_start    = (cur_state == RUN) || (cur_state == PAUSE);
  assign cnt_continue = (cur_state != PAUSE);
  assign cnt_load_en  = load_en_r;
  assign cnt_load     = load_r;
  assign cnt_dir      = dir_r;
  assign state        = cur_state;
  assign wrap_cnt     = wrap_r;
  assign irq          = irq_r;
  assign cmd_err      = err_r;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed self-checking bench for counter_ctrl; honours COUNTER_CTRL_AUTO_STOP_EN if defined.
module tb_counter_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [31:0] cmd_data = '0;
  logic        cnt_reset, cnt_start, cnt_continue, cnt_load_en, cnt_dir;
  logic [31:0] cnt_load;
  logic        cnt_pulse = 1'b0;
  logic [2:0]  state;
  logic [15:0] wrap_cnt;
  logic        irq, cmd_err;

  int vectors = 0;
  int miscompares = 0;

`ifdef COUNTER_CTRL_AUTO_STOP_EN
  localparam logic [31:0] STATE_AFTER_HIT = 32'd3;
  localparam logic [31:0] STATE_AFTER_PAUSE_HIT = 32'd3;
`else
  localparam logic [31:0] STATE_AFTER_HIT = 32'd1;
  localparam logic [31:0] STATE_AFTER_PAUSE_HIT = 32'd2;
`endif

  always #5 clk = ~clk;

  counter_ctrl #(.BIT_WIDTH(32), .WRAP_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cnt_reset(cnt_reset),
    .cnt_start(cnt_start), .cnt_continue(cnt_continue), .cnt_load_en(cnt_load_en),
    .cnt_load(cnt_load), .cnt_dir(cnt_dir), .cnt_pulse(cnt_pulse), .state(state),
    .wrap_cnt(wrap_cnt), .irq(irq), .cmd_err(cmd_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One command for exactly one accepting edge; outputs are sampled 1 time unit later.
  task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset behaviour.
    tick();
    check_output("rst_cnt_reset", 32'(cnt_reset), 32'd1);
    check_output("rst_state", 32'(state), 32'd0);
    check_output("rst_ready", 32'(cmd_ready), 32'd1);
    check_output("rst_start", 32'(cnt_start), 32'd0);
    check_output("rst_continue", 32'(cnt_continue), 32'd1);
    check_output("rst_load_en", 32'(cnt_load_en), 32'd0);
    check_output("rst_load", cnt_load, 32'd0);
    check_output("rst_dir", 32'(cnt_dir), 32'd1);
    check_output("rst_wrap", 32'(wrap_cnt), 32'd0);
    check_output("rst_irq", 32'(irq), 32'd0);
    check_output("rst_err", 32'(cmd_err), 32'd0);
    reset = 1'b0;
    tick();
    check_output("idle_cnt_reset", 32'(cnt_reset), 32'd0);
    check_output("idle_load_en", 32'(cnt_load_en), 32'd1);
    check_output("idle_state", 32'(state), 32'd0);

    // Load then run.
    apply_stimulus(3'd1, 32'h2A);
    check_output("load_value", cnt_load, 32'h2A);
    check_output("load_idle_state", 32'(state), 32'd0);
    apply_stimulus(3'd2, 32'd0);
    check_output("run_state", 32'(state), 32'd1);
    check_output("run_start", 32'(cnt_start), 32'd1);
    check_output("run_continue", 32'(cnt_continue), 32'd1);
    check_output("run_wrap", 32'(wrap_cnt), 32'd0);

    // Pause / resume / stop / rerun.
    apply_stimulus(3'd3, 32'd0);
    check_output("pause_state", 32'(state), 32'd2);
    check_output("pause_continue", 32'(cnt_continue), 32'd0);
    check_output("pause_start", 32'(cnt_start), 32'd1);
    apply_stimulus(3'd4, 32'd0);
    check_output("resume_state", 32'(state), 32'd1);
    check_output("resume_continue", 32'(cnt_continue), 32'd1);
    cnt_pulse = 1'b1;
    tick();
    check_output("wrap_one", 32'(wrap_cnt), 32'd1);
    cnt_pulse = 1'b0;
    tick();
    apply_stimulus(3'd5, 32'd0);
    check_output("stop_state", 32'(state), 32'd3);
    check_output("stop_start", 32'(cnt_start), 32'd0);
    check_output("stop_continue", 32'(cnt_continue), 32'd1);
    check_output("stop_keeps_wrap", 32'(wrap_cnt), 32'd1);
    apply_stimulus(3'd2, 32'd0);
    check_output("rerun_state", 32'(state), 32'd1);
    check_output("rerun_clears_wrap", 32'(wrap_cnt), 32'd0);

    // Reload mid-run goes through a one-cycle flush.
    apply_stimulus(3'd1, 32'h10);
    check_output("flush_state", 32'(state), 32'd4);
    check_output("flush_ready", 32'(cmd_ready), 32'd0);
    check_output("flush_cnt_reset", 32'(cnt_reset), 32'd1);
    tick();
    check_output("post_flush_state", 32'(state), 32'd0);
    check_output("post_flush_ready", 32'(cmd_ready), 32'd1);
    check_output("post_flush_cnt_reset", 32'(cnt_reset), 32'd0);
    check_output("post_flush_load", cnt_load, 32'h10);

    // Illegal PAUSE in IDLE.
    apply_stimulus(3'd3, 32'd0);
    check_output("err_pulse", 32'(cmd_err), 32'd1);
    check_output("err_state", 32'(state), 32'd0);
    tick();
    check_output("err_one_cycle", 32'(cmd_err), 32'd0);

    // Wrap target of 3 reached by three 2-cycle pulse bursts.
    apply_stimulus(3'd7, 32'd3);
    apply_stimulus(3'd2, 32'd0);
    check_output("wraps_run_state", 32'(state), 32'd1);
    for (int b = 1; b <= 3; b++) begin
      cnt_pulse = 1'b1;
      tick();
      check_output($sformatf("burst%0d_wrap", b), 32'(wrap_cnt), 32'(b));
      check_output($sformatf("burst%0d_irq", b), 32'(irq), (b == 3) ? 32'd1 : 32'd0);
      if (b == 3) check_output("hit_state", 32'(state), STATE_AFTER_HIT);
      tick();
      check_output($sformatf("burst%0d_irq_hold", b), 32'(irq), 32'd0);
      check_output($sformatf("burst%0d_wrap_hold", b), 32'(wrap_cnt), 32'(b));
      cnt_pulse = 1'b0;
      tick();
      tick();
    end

    // RUN accepted in the same cycle as a wrap edge: clear wins, no irq.
    apply_stimulus(3'd2, 32'd0);
    check_output("rerun2_wrap", 32'(wrap_cnt), 32'd0);
    apply_stimulus(3'd7, 32'd1);
    cnt_pulse = 1'b1;
    apply_stimulus(3'd2, 32'd0);
    check_output("clash_wrap", 32'(wrap_cnt), 32'd0);
    check_output("clash_irq", 32'(irq), 32'd0);
    cnt_pulse = 1'b0;
    tick();

    // PAUSE in the same cycle as a wrap edge still counts it.
    cnt_pulse = 1'b1;
    apply_stimulus(3'd3, 32'd0);
    check_output("pause_wrap_count", 32'(wrap_cnt), 32'd1);
    check_output("pause_wrap_irq", 32'(irq), 32'd1);
    check_output("pause_wrap_state", 32'(state), STATE_AFTER_PAUSE_HIT);
    cnt_pulse = 1'b0;

    // Direction change.
    apply_stimulus(3'd6, 32'd0);
    check_output("dir_down", 32'(cnt_dir), 32'd0);

    // Reset abandons an in-flight flush.
    apply_stimulus(3'd1, 32'h55);
    check_output("flush2_state", 32'(state), 32'd4);
    reset = 1'b1;
    tick();
    check_output("abort_state", 32'(state), 32'd0);
    check_output("abort_load", cnt_load, 32'd0);
    check_output("abort_dir", 32'(cnt_dir), 32'd1);
    check_output("abort_ready", 32'(cmd_ready), 32'd1);
    check_output("abort_cnt_reset", 32'(cnt_reset), 32'd1);
    reset = 1'b0;
    tick();
    check_output("abort_release", 32'(cnt_reset), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
